// File: rtl/seq_gen_detector_param.sv
// Round-robin serialiser of NWORDS words (MSB first) with Mealy/Moore pattern detectors and
// saturating hit counters. Define SEQ_HIT_POS_EN to add last-hit word/bit position outputs.
module seq_gen_detector_param #(
  parameter int unsigned        WIDTH   = 16,
  parameter int unsigned        NWORDS  = 3,
  parameter int unsigned        PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter int unsigned        CNT_W   = 16,
  localparam int unsigned       WI_W    = (NWORDS > 1) ? $clog2(NWORDS) : 1,
  localparam int unsigned       BI_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                    clk_i,
  input  logic                    res_i,
  input  logic                    en_i,
  input  logic                    overlap_i,
  input  logic [NWORDS*WIDTH-1:0] words_i,
  output logic                    data_out_o,
  output logic [WI_W-1:0]         word_idx_o,
  output logic [BI_W-1:0]         bit_idx_o,
  output logic                    mealy_f_o,
  output logic                    moore_f_o,
  output logic [CNT_W-1:0]        mealy_cnt_o,
  output logic [CNT_W-1:0]        moore_cnt_o
`ifdef SEQ_HIT_POS_EN
  ,
  output logic [WI_W-1:0]         last_hit_word_o,
  output logic [BI_W-1:0]         last_hit_bit_o
`endif
);

  localparam int unsigned HW     = PAT_LEN - 1;
  localparam int unsigned FILL_W = $clog2(PAT_LEN);
  localparam logic [BI_W-1:0]   BitLast  = BI_W'(WIDTH - 1);
  localparam logic [WI_W-1:0]   WordLast = WI_W'(NWORDS - 1);
  localparam logic [FILL_W-1:0] FillFull = FILL_W'(PAT_LEN - 1);

  typedef enum logic [1:0] {StIdle, StFill, StArmed} state_e;

  state_e             state_q, state_d;
  logic [WI_W-1:0]    word_idx_q, word_idx_d;
  logic [BI_W-1:0]    bit_idx_q, bit_idx_d;
  logic [HW-1:0]      hist_q, hist_d;
  logic [FILL_W-1:0]  fill_q, fill_d, fill_inc;
  logic               moore_q, moore_d;
  logic [CNT_W-1:0]   mealy_cnt_q, mealy_cnt_d, moore_cnt_q, moore_cnt_d;
  logic [WIDTH-1:0]   cur_word;
  logic [PAT_LEN-1:0] window;

  // Live word select: a change on words_i shows up on the very next read.
  always_comb begin
    cur_word = '0;
    for (int unsigned k = 0; k < NWORDS; k++) begin
      if (word_idx_q == WI_W'(k)) cur_word = words_i[k*WIDTH +: WIDTH];
    end
    data_out_o = cur_word[BitLast - bit_idx_q];
    window     = {hist_q, data_out_o};
    mealy_f_o  = en_i && (state_q == StArmed) && (window == PATTERN);
  end

  always_comb begin
    word_idx_d = word_idx_q;
    bit_idx_d  = bit_idx_q;
    hist_d     = hist_q;
    fill_d     = fill_q;
    state_d    = state_q;
    fill_inc   = (fill_q == FillFull) ? fill_q : fill_q + 1'b1;
    if (en_i) begin
      hist_d = window[HW-1:0];
      if (bit_idx_q == BitLast) begin
        bit_idx_d  = '0;
        word_idx_d = (word_idx_q == WordLast) ? '0 : word_idx_q + 1'b1;
      end else begin
        bit_idx_d = bit_idx_q + 1'b1;
      end
      case (state_q)
        StIdle, StFill: begin
          fill_d  = fill_inc;
          state_d = (fill_inc == FillFull) ? StArmed : StFill;
        end
        StArmed: begin
          // Non-overlapped: history is kept but ignored until a full refill.
          if (mealy_f_o && !overlap_i) begin
            fill_d  = '0;
            state_d = StFill;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    moore_d     = mealy_f_o;
    mealy_cnt_d = mealy_cnt_q;
    moore_cnt_d = moore_cnt_q;
    if (mealy_f_o && (mealy_cnt_q != '1)) mealy_cnt_d = mealy_cnt_q + 1'b1;
    if (moore_q && (moore_cnt_q != '1)) moore_cnt_d = moore_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (res_i) begin
      state_q     <= StIdle;
      word_idx_q  <= '0;
      bit_idx_q   <= '0;
      hist_q      <= '0;
      fill_q      <= '0;
      moore_q     <= 1'b0;
      mealy_cnt_q <= '0;
      moore_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      word_idx_q  <= word_idx_d;
      bit_idx_q   <= bit_idx_d;
      hist_q      <= hist_d;
      fill_q      <= fill_d;
      moore_q     <= moore_d;
      mealy_cnt_q <= mealy_cnt_d;
      moore_cnt_q <= moore_cnt_d;
    end
  end

  assign word_idx_o  = word_idx_q;
  assign bit_idx_o   = bit_idx_q;
  assign moore_f_o   = moore_q;
  assign mealy_cnt_o = mealy_cnt_q;
  assign moore_cnt_o = moore_cnt_q;

`ifdef SEQ_HIT_POS_EN
  logic [WI_W-1:0] hit_word_q;
  logic [BI_W-1:0] hit_bit_q;

  always_ff @(posedge clk_i) begin
    if (res_i) begin
      hit_word_q <= '0;
      hit_bit_q  <= '0;
    end else if (mealy_f_o) begin
      hit_word_q <= word_idx_q;
      hit_bit_q  <= bit_idx_q;
    end
  end

  assign last_hit_word_o = hit_word_q;
  assign last_hit_bit_o  = hit_bit_q;
`endif

endmodule

// File: tb/tb_seq_gen_detector_param.sv
// Bench for seq_gen_detector_param: three instances (PATTERN 1111, 1011, and 1111 with 4-bit
// counters) share one stimulus; a bit-level model plus a Moore scoreboard checks every cycle.
module tb_seq_gen_detector_param;
  localparam int W  = 16;
  localparam int NW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          res_r, en_r, ovl_r;
  logic [47:0]   words_r;

  logic          data_a, data_b, data_c;
  logic [1:0]    widx_a, widx_b, widx_c;
  logic [3:0]    bidx_a, bidx_b, bidx_c;
  logic          mealy_a, mealy_b, mealy_c, moore_a, moore_b, moore_c;
  logic [15:0]   mcnt_a, ocnt_a, mcnt_b, ocnt_b;
  logic [3:0]    mcnt_c, ocnt_c;
`ifdef SEQ_HIT_POS_EN
  logic [1:0]    lhw_a, lhw_b, lhw_c;
  logic [3:0]    lhb_a, lhb_b, lhb_c;
`endif

  seq_gen_detector_param #(.WIDTH(W), .NWORDS(NW), .PAT_LEN(4), .PATTERN(4'b1111), .CNT_W(16))
  u_a (
    .clk_i(clk), .res_i(res_r), .en_i(en_r), .overlap_i(ovl_r), .words_i(words_r),
    .data_out_o(data_a), .word_idx_o(widx_a), .bit_idx_o(bidx_a), .mealy_f_o(mealy_a),
    .moore_f_o(moore_a), .mealy_cnt_o(mcnt_a), .moore_cnt_o(ocnt_a)
`ifdef SEQ_HIT_POS_EN
    , .last_hit_word_o(lhw_a), .last_hit_bit_o(lhb_a)
`endif
  );

  seq_gen_detector_param #(.WIDTH(W), .NWORDS(NW), .PAT_LEN(4), .PATTERN(4'b1011), .CNT_W(16))
  u_b (
    .clk_i(clk), .res_i(res_r), .en_i(en_r), .overlap_i(ovl_r), .words_i(words_r),
    .data_out_o(data_b), .word_idx_o(widx_b), .bit_idx_o(bidx_b), .mealy_f_o(mealy_b),
    .moore_f_o(moore_b), .mealy_cnt_o(mcnt_b), .moore_cnt_o(ocnt_b)
`ifdef SEQ_HIT_POS_EN
    , .last_hit_word_o(lhw_b), .last_hit_bit_o(lhb_b)
`endif
  );

  seq_gen_detector_param #(.WIDTH(W), .NWORDS(NW), .PAT_LEN(4), .PATTERN(4'b1111), .CNT_W(4))
  u_c (
    .clk_i(clk), .res_i(res_r), .en_i(en_r), .overlap_i(ovl_r), .words_i(words_r),
    .data_out_o(data_c), .word_idx_o(widx_c), .bit_idx_o(bidx_c), .mealy_f_o(mealy_c),
    .moore_f_o(moore_c), .mealy_cnt_o(mcnt_c), .moore_cnt_o(ocnt_c)
`ifdef SEQ_HIT_POS_EN
    , .last_hit_word_o(lhw_c), .last_hit_bit_o(lhb_c)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
  endtask

  // Reference model state
  typedef struct { bit a; bit b; } mo_t;
  mo_t        sb_q[$];
  int         mw, mb, since_a, since_b;
  logic [2:0] shreg;
  int         mc_a, oc_a, mc_b, oc_b, mc_c, oc_c;
  int         lw_b, lb_b;

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    mo_t z;
    mw = 0; mb = 0; since_a = 0; since_b = 0; shreg = '0;
    mc_a = 0; oc_a = 0; mc_b = 0; oc_b = 0; mc_c = 0; oc_c = 0;
    lw_b = 0; lb_b = 0;
    z.a = 1'b0; z.b = 1'b0;
    sb_q.delete();
    sb_q.push_back(z);
  endtask

  // One clock: drive, check combinational and registered outputs, advance model, clock.
  task automatic step(input logic en, input logic rs);
    logic bitv, ha, hb;
    mo_t  exp_mo, nxt;
    en_r = en; res_r = rs;
    #1;
    bitv   = words_r[mw*W + (W-1-mb)];
    ha     = en && (since_a >= 3) && ({shreg, bitv} == 4'b1111);
    hb     = en && (since_b >= 3) && ({shreg, bitv} == 4'b1011);
    exp_mo = sb_q.pop_front();
    chk("data_out", data_a, bitv);
    chk("data_out_b", data_b, bitv);
    chk("word_idx", widx_a, mw);
    chk("bit_idx", bidx_a, mb);
    chk("mealy_a", mealy_a, ha);
    chk("mealy_b", mealy_b, hb);
    chk("mealy_c", mealy_c, ha);
    chk("moore_a", moore_a, exp_mo.a);
    chk("moore_b", moore_b, exp_mo.b);
    chk("moore_c", moore_c, exp_mo.a);
    chk("mcnt_a", mcnt_a, mc_a);
    chk("ocnt_a", ocnt_a, oc_a);
    chk("mcnt_b", mcnt_b, mc_b);
    chk("ocnt_b", ocnt_b, oc_b);
    chk("mcnt_c", mcnt_c, mc_c);
    chk("ocnt_c", ocnt_c, oc_c);
`ifdef SEQ_HIT_POS_EN
    chk("last_hit_word_b", lhw_b, lw_b);
    chk("last_hit_bit_b", lhb_b, lb_b);
`endif
    if (rs) begin
      model_reset();
    end else begin
      mc_a = sat(mc_a + int'(ha), 65535);
      oc_a = sat(oc_a + int'(exp_mo.a), 65535);
      mc_b = sat(mc_b + int'(hb), 65535);
      oc_b = sat(oc_b + int'(exp_mo.b), 65535);
      mc_c = sat(mc_c + int'(ha), 15);
      oc_c = sat(oc_c + int'(exp_mo.a), 15);
      if (hb) begin lw_b = mw; lb_b = mb; end
      if (en) begin
        shreg   = {shreg[1:0], bitv};
        since_a = (ha && !ovl_r) ? 0 : sat(since_a + 1, 3);
        since_b = (hb && !ovl_r) ? 0 : sat(since_b + 1, 3);
        if (mb == W-1) begin
          mb = 0;
          mw = (mw == NW-1) ? 0 : mw + 1;
        end else begin
          mb++;
        end
      end
      nxt.a = ha; nxt.b = hb;
      sb_q.push_back(nxt);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic [47:0] words;
    logic        ovl;
    int          ncyc;
    int          ca, cb, cc;
    int          lw, lb;
  } vec_t;

  vec_t tbl[4];

  initial begin
    tbl[0] = '{words: {16'hFFFF, 16'hFFFF, 16'hFFFF}, ovl: 1'b1, ncyc: 48,
               ca: 45, cb: 0, cc: 15, lw: 0, lb: 0};
    tbl[1] = '{words: {16'hFFFF, 16'hFFFF, 16'hFFFF}, ovl: 1'b0, ncyc: 48,
               ca: 12, cb: 0, cc: 12, lw: 0, lb: 0};
    tbl[2] = '{words: {16'h0000, 16'h0000, 16'hB000}, ovl: 1'b1, ncyc: 96,
               ca: 0, cb: 2, cc: 0, lw: 0, lb: 3};
    tbl[3] = '{words: {16'h0000, 16'h6000, 16'h0001}, ovl: 1'b1, ncyc: 48,
               ca: 0, cb: 1, cc: 0, lw: 1, lb: 2};

    res_r = 1'b1; en_r = 1'b0; ovl_r = 1'b1; words_r = '0;
    @(posedge clk);
    @(negedge clk);
    model_reset();

    for (int i = 0; i < 4; i++) begin
      words_r = tbl[i].words;
      ovl_r   = tbl[i].ovl;
      step(1'b0, 1'b1);
      for (int c = 0; c < tbl[i].ncyc; c++) step(1'b1, 1'b0);
      chk("tbl_mealy_cnt_a", mcnt_a, tbl[i].ca);
      chk("tbl_mealy_cnt_b", mcnt_b, tbl[i].cb);
      chk("tbl_mealy_cnt_c", mcnt_c, tbl[i].cc);
      step(1'b0, 1'b0);
      chk("tbl_moore_cnt_a", ocnt_a, tbl[i].ca);
      chk("tbl_moore_cnt_b", ocnt_b, tbl[i].cb);
      chk("tbl_moore_cnt_c", ocnt_c, tbl[i].cc);
`ifdef SEQ_HIT_POS_EN
      chk("tbl_last_hit_word", lhw_b, tbl[i].lw);
      chk("tbl_last_hit_bit", lhb_b, tbl[i].lb);
`endif
    end

    // en dropped for 5 cycles after "10" of 1011: indices freeze, match completes later
    words_r = {16'h0000, 16'h0000, 16'hB000};
    ovl_r   = 1'b1;
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    repeat (5) step(1'b0, 1'b0);
    chk("frozen_bit_idx", bidx_b, 2);
    chk("frozen_word_idx", widx_b, 0);
    chk("frozen_no_hit", mcnt_b, 0);
    step(1'b1, 1'b0);
    chk("resume_no_hit_yet", mcnt_b, 0);
    step(1'b1, 1'b0);
    chk("resume_hit", mcnt_b, 1);
    step(1'b0, 1'b0);
    chk("resume_moore_cnt", ocnt_b, 1);

    // Reset on a Mealy-hit cycle: Moore pulse dropped, fresh fill needed afterwards
    words_r = {16'hFFFF, 16'hFFFF, 16'hFFFF};
    step(1'b0, 1'b1);
    repeat (6) step(1'b1, 1'b0);
    chk("pre_reset_cnt", mcnt_a, 3);
    step(1'b1, 1'b1);
    chk("rst_moore_dropped", moore_a, 0);
    chk("rst_mealy_cnt", mcnt_a, 0);
    chk("rst_moore_cnt", ocnt_a, 0);
    chk("rst_bit_idx", bidx_a, 0);
    chk("rst_word_idx", widx_a, 0);
    repeat (3) step(1'b1, 1'b0);
    chk("refill_no_hit", mcnt_a, 0);
    step(1'b1, 1'b0);
    chk("refill_first_hit", mcnt_a, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
